uart_tx_serializer: RTL and testbench

//  Downstream stage of the sorter: accepts sorted bytes over a valid/ready handshake and serializes each as one UART frame.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 40 ++++
 rtl/uart_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and baud counter sizing.
// Used by uart_tx_serializer and the future uart_rx block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Baud counter width for a given bit period; never narrower than one bit.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
)
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW   = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bit_done = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake, one frame in flight, registered TX line.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
)
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             tx_o,
    output logic             busy_o
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int            BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_tx_state_t   state_reg,   state_next;
    logic [WIDTH-1:0] shift_reg,   shift_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             tx_reg,      tx_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg,  parity_next;
`endif

    logic bit_done;
    logic last_stop;
    logic transfer;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable   (state_reg != IDLE),
        .clear    (state_reg == IDLE),
        .bit_done (bit_done)
    );

    // ready_o depends only on registered state, never on valid_i.
    assign last_stop = (state_reg == STOP) && bit_done && (bit_cnt_reg == LAST_STOP);
    assign ready_o   = (state_reg == IDLE) || last_stop;
    assign transfer  = valid_i && ready_o;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: ;
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next   = STOP;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A transfer is only possible in IDLE or on the final stop cycle.
        if (transfer) begin
            state_next   = START;
            shift_next   = data_i;
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            parity_next  = ^data_i;
`endif
        end

        // Line level is decoded from the next state so tx_o comes straight off a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign tx_o   = tx_reg;
    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4); a second instance covers STOP_BITS=2.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef bit bitq_t[$];
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // start, data LSB-first, stop; first transmitted bit in [9]
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, valid, ready, tx, busy;
    logic [7:0] data;
    logic       reset2, valid2, ready2, tx2, busy2;
    logic [7:0] data2;

    int n_vec = 0;
    int n_err = 0;
    int busy_cycles = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy)
    );

    uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .reset_i(reset2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_tx"},    32'(tx),    32'd1);
        check({tag, "_idle_busy"},  32'(busy),  32'd0);
        check({tag, "_idle_ready"}, 32'(ready), 32'd1);
    endtask

    // Reference frame from the protocol rules: start, LSB-first data, even parity, stops.
    function automatic bitq_t model_frame(input logic [7:0] d, input int stops);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (PAR_EN) q.push_back(bit'($countones(d) % 2));
        for (int s = 0; s < stops; s++) q.push_back(1'b1);
        return q;
    endfunction

    function automatic bitq_t table_frame(input vec_t v, input int stops);
        bitq_t q;
        for (int i = 9; i >= 1; i--) q.push_back(v.frame[i]);
        if (PAR_EN) q.push_back(v.par);
        for (int s = 0; s < stops; s++) q.push_back(v.frame[0]);
        return q;
    endfunction

    task automatic accept(input logic [7:0] d);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check("accept_ready_wait", 32'(guard < 200), 32'd1);
        data  = d;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    // Checks every cycle of a frame; optionally jitters valid/data while busy and chains the next byte.
    task automatic play(input string tag, input bitq_t exp, input bit noise,
                        input bit chain, input logic [7:0] next_d);
        int  total;
        bit  last;
        total = exp.size() * CPB;
        for (int k = 0; k < total; k++) begin
            last = (k == total - 1);
            check($sformatf("%s_tx[%0d]", tag, k),    32'(tx),    32'(exp[k / CPB]));
            check($sformatf("%s_busy[%0d]", tag, k),  32'(busy),  32'd1);
            check($sformatf("%s_ready[%0d]", tag, k), 32'(ready), 32'(last));
            if (busy === 1'b1) busy_cycles++;
            if (last) begin
                valid = chain;
                data  = next_d;
            end else begin
                valid = noise ? 1'($urandom % 2) : 1'b0;
                data  = 8'($urandom);
            end
            tick();
        end
        valid = 1'b0;
    endtask

    initial begin
        bitq_t      q;
        logic [7:0] rd[30];
        bit         chained, chain;

        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h81, 10'b0100000011, 1'b0};
        tbl[2] = '{8'h3C, 10'b0001111001, 1'b0};
        tbl[3] = '{8'h01, 10'b0100000001, 1'b1};
        tbl[4] = '{8'h80, 10'b0000000011, 1'b1};
        tbl[5] = '{8'h00, 10'b0000000001, 1'b0};
        tbl[6] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[7] = '{8'h55, 10'b0101010101, 1'b0};

        reset = 1'b1; valid = 1'b0; data = 8'h00;
        reset2 = 1'b1; valid2 = 1'b0; data2 = 8'h00;
        repeat (3) tick();
        reset = 1'b0; reset2 = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            check_idle($sformatf("reset%0d", i));
            tick();
        end

        // Table frames; the first one jitters valid_i and data_i while busy
        for (int i = 0; i < 5; i++) begin
            accept(tbl[i].data);
            play($sformatf("tbl%0d", i), table_frame(tbl[i], 1), (i == 0), 1'b0, 8'h00);
            check_idle($sformatf("tbl%0d", i));
        end

        // Back-to-back 0x00 then 0xFF with no idle gap
        busy_cycles = 0;
        check("b2b_ready_before", 32'(ready), 32'd1);
        data = 8'h00; valid = 1'b1;
        tick();
        valid = 1'b0;
        play("b2b0", table_frame(tbl[5], 1), 1'b0, 1'b1, 8'hFF);
        play("b2b1", table_frame(tbl[6], 1), 1'b0, 1'b0, 8'h00);
        check("b2b_busy_cycles", 32'(busy_cycles), PAR_EN ? 32'd88 : 32'd80);
        check_idle("b2b");

        // Reset in the middle of the third data bit of 0x3C, then a clean 0x81
        accept(8'h3C);
        repeat (3 * CPB + 1) tick();
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_ready_before", 32'(ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midrst");
        accept(8'h81);
        play("post_rst", table_frame(tbl[1], 1), 1'b0, 1'b0, 8'h00);
        check_idle("post_rst");

        // Two stop bits on the second instance
        check("stop2_ready", 32'(ready2), 32'd1);
        data2 = 8'h55; valid2 = 1'b1;
        tick();
        valid2 = 1'b0; data2 = 8'hAA;
        q = table_frame(tbl[7], 2);
        for (int k = 0; k < q.size() * CPB; k++) begin
            check($sformatf("stop2_tx[%0d]", k),    32'(tx2),    32'(q[k / CPB]));
            check($sformatf("stop2_ready[%0d]", k), 32'(ready2), 32'(k == q.size() * CPB - 1));
            tick();
        end
        check("stop2_idle_busy", 32'(busy2), 32'd0);
        check("stop2_idle_tx", 32'(tx2), 32'd1);

        // Randomized frames against the reference model, random chaining and jitter
        for (int i = 0; i < 30; i++) rd[i] = 8'($urandom);
        chained = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!chained) accept(rd[i]);
            chain = (i < 29) && ($urandom % 2 == 1);
            play($sformatf("rnd%0d", i), model_frame(rd[i], 1), 1'($urandom % 2),
                 chain, chain ? rd[(i + 1) % 30] : 8'h00);
            if (!chain) check_idle($sformatf("rnd%0d", i));
            chained = chain;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
